// File: rtl/memory_ctrl_queued_if.sv
// Request, completion and data-bus signals of the queued load/store unit.
// slave: the controller's view; master: the execute stage plus memory's view.
interface memory_ctrl_queued_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
);
    localparam int PW = $clog2(DEPTH + 1);

    logic [31:0]      instr;
    logic [31:0]      op1;
    logic [31:0]      op2;
    logic [31:0]      op3;
    logic [TAG_W-1:0] tag;
    logic             enable;
    logic             ready;
    logic             flush;
    logic [PW-1:0]    pending;
    logic [31:0]      result;
    logic             result_valid;
    logic             store_done;
    logic             fault;
    logic [1:0]       fault_code;
    logic [TAG_W-1:0] done_tag;
    logic [31:0]      address;
    logic             read_enable;
    logic [31:0]      read_data;
    logic             read_ack;
    logic             write_enable;
    logic [3:0]       write_byte_enable;
    logic [31:0]      write_data;
    logic             write_ack;

    modport slave (
        input  instr, op1, op2, op3, tag, enable, flush, read_data, read_ack, write_ack,
        output ready, pending, result, result_valid, store_done, fault, fault_code,
               done_tag, address, read_enable, write_enable, write_byte_enable, write_data
    );

    modport master (
        output instr, op1, op2, op3, tag, enable, flush, read_data, read_ack, write_ack,
        input  ready, pending, result, result_valid, store_done, fault, fault_code,
               done_tag, address, read_enable, write_enable, write_byte_enable, write_data
    );
endinterface

// File: rtl/memory_ctrl_queued.sv
// Queued RV32 load/store unit: decodes LW/LH/LHU/LB/LBU/SW/SH/SB, issues one access at a time.
// Latency: push edge N -> strobe N+1 -> ack sampled in WAIT -> done pulse N+3 with a zero-wait bus.
// Backpressure: ready drops when DEPTH requests are queued; pushes while full are dropped.
module memory_ctrl_queued #(
    parameter int DEPTH         = 4,
    parameter int TIMEOUT       = 16,
    parameter int TAG_W         = 4,
    parameter int random_errors = 0
) (
    input  logic clk,
    input  logic rst_n,
    memory_ctrl_queued_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;
    localparam logic [1:0] FC_NONE = 2'd0, FC_MISALIGN = 2'd1, FC_TIMEOUT = 2'd2;

    typedef struct packed {
        logic [1:0]       size;
        logic             sign_ex;
        logic             wr;
        logic             mis;
        logic [29:0]      waddr;
        logic [1:0]       off;
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    req_t            mem_q [DEPTH];
    req_t            cur_q, cur_d, new_req;
    logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PW-1:0]   count_q, count_d, pending_q, pending_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [1:0]      code_q, code_d;
    logic [31:0]     result_q, result_d, err_mask_q;
    logic [31:0]     ea, shifted, load_val;
    logic [2:0]      f3;
    logic            ready_q, ready_d, is_mem, push, pop, ack, active;

    always_comb begin
        ea     = bus.op1 + bus.op2;
        f3     = bus.instr[14:12];
        is_mem = 1'b0;
        // Loads allow funct3 000/001/010/100/101; stores 000/001/010.
        if (bus.instr[6:0] == OPC_LOAD)
            is_mem = (f3[1:0] != 2'b11) && !(f3[2] && f3[1]);
        else if (bus.instr[6:0] == OPC_STORE)
            is_mem = !f3[2] && (f3[1:0] != 2'b11);
        new_req.size    = f3[1:0];
        new_req.sign_ex = !f3[2];
        new_req.wr      = (bus.instr[6:0] == OPC_STORE);
        new_req.mis     = ((f3[1:0] == SZ_W) && (ea[1:0] != 2'b00)) ||
                          ((f3[1:0] == SZ_H) && (ea[1:0] == 2'b11));
        new_req.waddr   = ea[31:2];
        new_req.off     = ea[1:0];
        new_req.data    = bus.op3;
        new_req.tag     = bus.tag;
    end

    assign push = bus.enable & ready_q & is_mem;
    assign ack  = cur_q.wr ? bus.write_ack : bus.read_ack;

    always_comb begin
        shifted = bus.read_data >> {cur_q.off, 3'b000};
        case (cur_q.size)
            SZ_B:    load_val = {{24{cur_q.sign_ex & shifted[7]}}, shifted[7:0]};
            SZ_H:    load_val = {{16{cur_q.sign_ex & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        code_d   = code_q;
        tmo_d    = tmo_q;
        result_d = result_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: if (count_q != '0 && !bus.flush) begin
                pop     = 1'b1;
                cur_d   = mem_q[head_q];
                code_d  = FC_NONE;
                state_d = ADDR;
            end
            ADDR: if (cur_q.mis) begin
                code_d  = FC_MISALIGN;
                state_d = DONE;
            end else begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (ack) begin
                state_d = DONE;
                if (!cur_q.wr) result_d = load_val ^ err_mask_q;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                code_d  = FC_TIMEOUT;
                state_d = DONE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Flush also swallows a same-cycle push: the tail snaps back to the head.
        head_d  = head_q + AW'(pop);
        tail_d  = tail_q + AW'(push);
        count_d = count_q + PW'(push) - PW'(pop);
        if (bus.flush) begin
            tail_d  = head_q;
            count_d = '0;
        end
        ready_d   = (count_d != PW'(DEPTH));
        pending_d = count_d + PW'(state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            code_q    <= FC_NONE;
            tmo_q     <= '0;
            result_q  <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            ready_q   <= 1'b0;
            pending_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            code_q    <= code_d;
            tmo_q     <= tmo_d;
            result_q  <= result_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            pending_q <= pending_d;
            if (push) mem_q[tail_q] <= new_req;
        end
    end

`ifdef SYNTHESIS
    assign err_mask_q = '0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_mask_q <= '0;
        else if (random_errors != 0 && $urandom_range(9) == 0)
            err_mask_q <= 32'd1 << $urandom_range(31);
        else
            err_mask_q <= '0;
    end
`endif

    assign active = (state_q == ADDR) || (state_q == WAIT);

    always_comb begin
        bus.ready             = ready_q;
        bus.pending           = pending_q;
        bus.result            = result_q;
        bus.read_enable       = (state_q == ADDR) && !cur_q.mis && !cur_q.wr;
        bus.write_enable      = (state_q == ADDR) && !cur_q.mis && cur_q.wr;
        bus.address           = active ? {2'b00, cur_q.waddr} : 32'h0;
        bus.write_byte_enable = 4'h0;
        bus.write_data        = 32'h0;
        if (active && cur_q.wr) begin
            case (cur_q.size)
                SZ_B: begin
                    bus.write_byte_enable = 4'h1 << cur_q.off;
                    bus.write_data        = {24'h0, cur_q.data[7:0]} << {cur_q.off, 3'b000};
                end
                SZ_H: begin
                    bus.write_byte_enable = 4'h3 << cur_q.off;
                    bus.write_data        = {16'h0, cur_q.data[15:0]} << {cur_q.off, 3'b000};
                end
                default: begin
                    bus.write_byte_enable = 4'hF;
                    bus.write_data        = cur_q.data;
                end
            endcase
        end
        bus.result_valid = (state_q == DONE) && (code_q == FC_NONE) && !cur_q.wr;
        bus.store_done   = (state_q == DONE) && (code_q == FC_NONE) && cur_q.wr;
        bus.fault        = (state_q == DONE) && (code_q != FC_NONE);
        bus.fault_code   = (state_q == DONE) ? code_q : FC_NONE;
        bus.done_tag     = (state_q == DONE) ? cur_q.tag : '0;
    end
endmodule
